// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   FIFO of committed stores sitting between the MEM stage and the data-cache
//   controller. Store hits retire here instead of writing the cache array; the
//   oldest entry is offered to the cache on the drain interface, and loads in
//   MEM get the youngest matching store data forwarded combinationally.
//
// Ports
//   clock, reset             : system clock, asynchronous active-high reset
//   push_valid/addr/data     : committed store from MEM (addr bits [1:0] ignored)
//   push_ready               : store accepted when push_valid is also high
//   ld_valid, ld_addr        : MEM-stage load lookup
//   fwd_hit, fwd_data        : youngest matching entry (0 when no hit)
//   sb_drain_valid/addr/data : head entry offered to the cache
//   sb_drain_done            : cache wrote the head this cycle
//   force_drain              : cache must service drains before CPU requests
//   flush_req, flush_done    : empty-the-buffer request / one-cycle completion
//   empty, count             : occupancy
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_valid,
    input  logic [31:0]      push_addr,
    input  logic [31:0]      push_data,
    output logic             push_ready,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    output logic             fwd_hit,
    output logic [31:0]      fwd_data,
    output logic             sb_drain_valid,
    output logic [31:0]      sb_drain_addr,
    output logic [31:0]      sb_drain_data,
    input  logic             sb_drain_done,
    output logic             force_drain,
    input  logic             flush_req,
    output logic             flush_done,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam int CW = PTR_W + 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Entry storage: word address and data. Validity is implied by head/count.
    logic [29:0]      addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    state_t           state_q;
    logic             flush_done_q;

    logic             push_fire;
    logic             drain_fire;
    logic [PTR_W-1:0] fwd_idx;

    // Byte-offset bits are architecturally ignored on both address inputs.
    logic             unused_addr_bits;
    assign unused_addr_bits = ^{push_addr[1:0], ld_addr[1:0]};

    assign push_ready = (count_q < CW'(DEPTH)) && (state_q == RUN);
    assign push_fire  = push_valid && push_ready;
    // A done strobe with nothing buffered is ignored.
    assign drain_fire = sb_drain_done && (count_q != '0);

    // Pointer and occupancy next-state. Simultaneous push and drain leave the
    // count unchanged while both pointers advance.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_fire) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (drain_fire) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({push_fire, drain_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: the entry array is deliberately not reset; head/count already mark
    // every slot as invalid after reset, so clearing the data buys nothing.
    always_ff @(posedge clock) begin
        if (push_fire) begin
            addr_mem[tail_q] <= push_addr[31:2];
            data_mem[tail_q] <= push_data;
        end
    end

    // Pointers, occupancy and the RUN/FLUSH controller.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: state uses non-blocking assignments so every flop samples
            // the pre-edge values regardless of statement order.
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            state_q      <= RUN;
            flush_done_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            flush_done_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (flush_req) begin
                        // Already (or about to be) empty: complete at once.
                        if (count_d == '0) begin
                            flush_done_q <= 1'b1;
                        end else begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // Further flush requests are absorbed by the one in flight.
                    if (count_d == '0) begin
                        state_q      <= RUN;
                        flush_done_q <= 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign force_drain    = (state_q == FLUSH) || (count_q == CW'(DEPTH));
    assign flush_done     = flush_done_q;
    assign empty          = (count_q == '0);
    assign count          = count_q;
    assign sb_drain_valid = (count_q != '0);
    assign sb_drain_addr  = {addr_mem[head_q], 2'b00};
    assign sb_drain_data  = data_mem[head_q];

    // Forwarding: walk entries oldest to youngest so the last match wins.
    // The slot being pushed this cycle is outside [head, head+count) and thus
    // invisible; the slot being drained is still inside and thus visible.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if (ld_valid && (CW'(i) < count_q) && (addr_mem[fwd_idx] == ld_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[fwd_idx];
            end
        end
    end

endmodule
